// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions for the rotation (sine) and vectoring datapaths.
// Angles are Q2.13 radians (8192 = 1.0 rad). Also holds the arctangent
// table, the inverse CORDIC gain and the controller state encoding.
package cordic_pkg;

  localparam int unsigned AngleW    = 16;
  localparam int unsigned AngleFrac = 13;

  // pi in Q2.13
  localparam logic [15:0] PI_Q13 = 16'd25736;

  // 1/K = 0.60725 in Q2.13
  localparam logic [12:0] CORDIC_INV_GAIN_Q13 = 13'd4975;

  // round(atan(2^-i) * 8192), i = 0..15
  localparam logic [15:0] ATAN_LUT [16] = '{
    16'd6434, 16'd3798, 16'd2007, 16'd1019, 16'd511, 16'd256, 16'd128, 16'd64,
    16'd32,   16'd16,   16'd8,    16'd4,    16'd2,   16'd1,   16'd0,   16'd0
  };

  // Controller states
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StIter  = 2'd1;
  localparam state_t StScale = 2'd2;

endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring-mode CORDIC micro-rotation, purely combinational.
// Rotates (x, y) towards the positive x axis by atan(2^-i) and accumulates
// the applied angle into z.
//   x_i, y_i, z_i : current state (signed, W_INT bits)
//   iter_i        : micro-rotation index 0..15
//   x_o, y_o, z_o : state after this micro-rotation
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int unsigned W_INT = 18
) (
  input  logic signed [W_INT-1:0] x_i,
  input  logic signed [W_INT-1:0] y_i,
  input  logic signed [W_INT-1:0] z_i,
  input  logic        [3:0]       iter_i,
  output logic signed [W_INT-1:0] x_o,
  output logic signed [W_INT-1:0] y_o,
  output logic signed [W_INT-1:0] z_o
);

  logic signed [W_INT-1:0] x_sh;
  logic signed [W_INT-1:0] y_sh;
  logic signed [W_INT-1:0] atan_ext;

  always_comb begin
    x_sh     = x_i >>> iter_i;
    y_sh     = y_i >>> iter_i;
    atan_ext = {{(W_INT-16){1'b0}}, ATAN_LUT[iter_i]};
    // Positive y: rotate clockwise, so the accumulated angle grows.
    if (!y_i[W_INT-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_ext;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_ext;
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// Vectoring-mode CORDIC: converts a Cartesian pair (X, Y) into polar form.
// Angle_o = atan2(Y, X) in Q2.13 radians, Magnitude_o = sqrt(X^2 + Y^2)
// with the CORDIC gain removed. One micro-rotation per clock.
//   Clk_i, Rst_ni : clock, asynchronous active-low reset
//   X_i, Y_i      : signed inputs, captured only when a Start is accepted
//   Start_i       : request, honoured only while idle
//   Angle_o       : signed Q2.13 angle, held until the next result
//   Magnitude_o   : unsigned magnitude, same LSB weight as X_i/Y_i
//   Busy_o        : conversion in flight
//   Done_o        : one-cycle pulse when a new result is on the outputs
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int unsigned ITER  = 16,
  parameter int unsigned W_INT = 18
) (
  input  logic        Clk_i,
  input  logic        Rst_ni,
  input  logic [15:0] X_i,
  input  logic [15:0] Y_i,
  input  logic        Start_i,
  output logic [15:0] Angle_o,
  output logic [15:0] Magnitude_o,
  output logic        Busy_o,
  output logic        Done_o
);

  localparam int unsigned ProdW = W_INT + 13;

  state_t                  state_q, state_d;
  logic        [3:0]       iter_q, iter_d;
  logic signed [W_INT-1:0] x_q, x_d;
  logic signed [W_INT-1:0] y_q, y_d;
  logic signed [W_INT-1:0] z_q, z_d;
  logic                    zero_q, zero_d;
  logic        [15:0]      angle_q, angle_d;
  logic        [15:0]      mag_q, mag_d;
  logic                    done_q, done_d;

  logic signed [W_INT-1:0] x_nxt, y_nxt, z_nxt;
  logic signed [W_INT-1:0] x_in, y_in, pi_ext;
  logic        [ProdW-1:0] prod;
  logic        [W_INT-1:0] mag_full;

  cordic_vec_stage #(
    .W_INT (W_INT)
  ) u_stage (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .iter_i (iter_q),
    .x_o    (x_nxt),
    .y_o    (y_nxt),
    .z_o    (z_nxt)
  );

  always_comb begin
    x_in   = {{(W_INT-16){X_i[15]}}, X_i};
    y_in   = {{(W_INT-16){Y_i[15]}}, Y_i};
    pi_ext = {{(W_INT-16){1'b0}}, PI_Q13};

    // x is never negative after the pre-rotation; gate anyway for safety.
    prod     = {{13{1'b0}}, x_q} * ProdW'(CORDIC_INV_GAIN_Q13);
    mag_full = W_INT'(prod >> AngleFrac);

    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start_i) begin
          state_d = StIter;
          iter_d  = 4'd0;
          // (0,0) would otherwise accumulate the whole LUT into z.
          zero_d  = (X_i == 16'd0) && (Y_i == 16'd0);
          // Left half-plane: rotate by pi so the iterations only see x >= 0.
          // Y == 0 takes +pi so the negative real axis reports +pi.
          if (X_i[15]) begin
            x_d = -x_in;
            y_d = -y_in;
            z_d = Y_i[15] ? -pi_ext : pi_ext;
          end else begin
            x_d = x_in;
            y_d = y_in;
            z_d = '0;
          end
        end
      end
      StIter: begin
        x_d    = x_nxt;
        y_d    = y_nxt;
        z_d    = z_nxt;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'(ITER - 1)) begin
          state_d = StScale;
        end
      end
      StScale: begin
        state_d = StIdle;
        done_d  = 1'b1;
        angle_d = zero_q ? 16'd0 : z_q[15:0];
        if (x_q[W_INT-1]) begin
          mag_d = 16'd0;
        end else if (|mag_full[W_INT-1:16]) begin
          mag_d = 16'hffff;
        end else begin
          mag_d = mag_full[15:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      state_q <= StIdle;
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
    end
  end

  assign Angle_o     = angle_q;
  assign Magnitude_o = mag_q;
  assign Done_o      = done_q;
  assign Busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_cordic_vector.sv
// Directed bench for cordic_vector: hand-computed atan2/hypot results,
// handshake timing, back-to-back starts and asynchronous abort.
module tb_cordic_vector;

  logic        Clk_i   = 1'b0;
  logic        Rst_ni  = 1'b0;
  logic [15:0] X_i     = '0;
  logic [15:0] Y_i     = '0;
  logic        Start_i = 1'b0;
  logic [15:0] Angle_o;
  logic [15:0] Magnitude_o;
  logic        Busy_o;
  logic        Done_o;

  int n_checks = 0;
  int n_errors = 0;

  cordic_vector u_dut (
    .Clk_i       (Clk_i),
    .Rst_ni      (Rst_ni),
    .X_i         (X_i),
    .Y_i         (Y_i),
    .Start_i     (Start_i),
    .Angle_o     (Angle_o),
    .Magnitude_o (Magnitude_o),
    .Busy_o      (Busy_o),
    .Done_o      (Done_o)
  );

  always #5 Clk_i = ~Clk_i;

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    n_checks++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  // Present a request before edge E0, return at E0+1 with new inputs applied.
  task automatic start_conv(input int x, input int y, input int nx, input int ny,
                            input logic keep_start);
    @(negedge Clk_i);
    X_i     = 16'(x);
    Y_i     = 16'(y);
    Start_i = 1'b1;
    @(posedge Clk_i);
    #1;
    X_i     = 16'(nx);
    Y_i     = 16'(ny);
    Start_i = keep_start;
  endtask

  // Called at E0+1. Counts edges to Done_o and watches Busy_o / output hold.
  task automatic finish_conv(input string tag, input int exp_ang, input int exp_mag,
                             input int tol_ang, input int tol_mag);
    int   lat;
    int   gaps;
    int   changes;
    logic [15:0] ang0;
    logic [15:0] mag0;
    lat     = 0;
    gaps    = 0;
    changes = 0;
    ang0    = Angle_o;
    mag0    = Magnitude_o;
    while (Done_o !== 1'b1 && lat < 40) begin
      if (Busy_o !== 1'b1) gaps++;
      if (Angle_o !== ang0 || Magnitude_o !== mag0) changes++;
      @(posedge Clk_i);
      #1;
      lat++;
    end
    check({tag, ".latency"}, lat, 17, 0);
    check({tag, ".busy_run"}, gaps, 0, 0);
    check({tag, ".hold"}, changes, 0, 0);
    check({tag, ".angle"}, int'($signed(Angle_o)), exp_ang, tol_ang);
    check({tag, ".mag"}, int'(Magnitude_o), exp_mag, tol_mag);
    check({tag, ".busy_done"}, int'(Busy_o), 0, 0);
    @(posedge Clk_i);
    #1;
    check({tag, ".done_width"}, int'(Done_o), 0, 0);
  endtask

  localparam int NVec = 10;
  int xs      [NVec] = '{8192, 0,     -8192, -8192,  0, -32768, 32767,  0,     12000, -12000};
  int ys      [NVec] = '{8192, 8192,  0,     -1,     0, -32768, -32768, -8192, 16000, 16000};
  int exp_ang [NVec] = '{6434, 12868, 25736, -25735, 0, -19302, -6434,  -12868, 7596, 18140};
  int exp_mag [NVec] = '{11585, 8192, 8192,  8192,   0, 46341,  46340,  8192,  20000, 20000};
  int tol_ang [NVec] = '{4,    4,     4,     4,      0, 4,      4,      4,     4,     4};
  int tol_mag [NVec] = '{4,    4,     4,     4,      0, 8,      8,      4,     8,     8};

  initial begin
    int dones;

    // Reset state
    #23;
    check("rst.angle", int'(Angle_o), 0, 0);
    check("rst.mag", int'(Magnitude_o), 0, 0);
    check("rst.busy", int'(Busy_o), 0, 0);
    check("rst.done", int'(Done_o), 0, 0);
    @(negedge Clk_i);
    Rst_ni = 1'b1;

    // Directed vectors; inputs are scrambled right after E0.
    for (int k = 0; k < NVec; k++) begin
      start_conv(xs[k], ys[k], ~xs[k], ~ys[k], 1'b0);
      finish_conv($sformatf("vec%0d", k), exp_ang[k], exp_mag[k], tol_ang[k], tol_mag[k]);
    end

    // Start held high: first run uses E0 inputs, second is accepted at E18.
    start_conv(0, 8192, 8192, 8192, 1'b1);
    finish_conv("b2b_first", 12868, 8192, 4, 4);
    check("b2b.busy_restart", int'(Busy_o), 1, 0);
    Start_i = 1'b0;
    finish_conv("b2b_second", 6434, 11585, 4, 4);

    // Abort around iteration 8: outputs clear asynchronously, no Done.
    start_conv(0, 8192, 0, 0, 1'b0);
    repeat (9) @(posedge Clk_i);
    #2;
    Rst_ni = 1'b0;
    #1;
    check("abort.angle", int'(Angle_o), 0, 0);
    check("abort.mag", int'(Magnitude_o), 0, 0);
    check("abort.busy", int'(Busy_o), 0, 0);
    check("abort.done", int'(Done_o), 0, 0);
    #4;
    Rst_ni = 1'b1;
    dones = 0;
    repeat (25) begin
      @(posedge Clk_i);
      #1;
      if (Done_o === 1'b1) dones++;
    end
    check("abort.no_done", dones, 0, 0);

    start_conv(8192, 8192, 1, 1, 1'b0);
    finish_conv("after_abort", 6434, 11585, 4, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
